// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the RV32M divide unit.
// Contents:
//   DIV_DATA_WIDTH / DIV_CNT_WIDTH  default operand and counter widths
//   div_op_e                        DIV/DIVU/REM/REMU encoding; the decoder uses the same values
//   div_state_e                     controller states
//   is_signed_op / is_rem_op        helpers that decode an op
package div_ctrl_pkg;

  localparam int DIV_DATA_WIDTH = 32;
  localparam int DIV_CNT_WIDTH  = 5;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    DIV_STATE_IDLE = 2'b00,
    DIV_STATE_CALC = 2'b01,
    DIV_STATE_DONE = 2'b10
  } div_state_e;

  function automatic logic is_signed_op(input div_op_e op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

  function automatic logic is_rem_op(input div_op_e op);
    return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
  endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Request/response bundle between EX and the divide unit.
// Signals:
//   div_req_i, div_op_i, dividend_i, divisor_i, flush_i   EX -> divider
//   div_busy_o, div_stall_o, div_valid_o, div_result_o    divider -> EX/writeback
// Modports: master (EX side), slave (divider side).
interface div_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  div_req_i;
  logic [1:0]            div_op_i;
  logic [DATA_WIDTH-1:0] dividend_i;
  logic [DATA_WIDTH-1:0] divisor_i;
  logic                  flush_i;
  logic                  div_busy_o;
  logic                  div_stall_o;
  logic                  div_valid_o;
  logic [DATA_WIDTH-1:0] div_result_o;

  modport master (
    output div_req_i, div_op_i, dividend_i, divisor_i, flush_i,
    input  div_busy_o, div_stall_o, div_valid_o, div_result_o
  );

  modport slave (
    input  div_req_i, div_op_i, dividend_i, divisor_i, flush_i,
    output div_busy_o, div_stall_o, div_valid_o, div_result_o
  );
endinterface

// File: rtl/div_step.sv
// One combinational radix-2 restoring division step.
// Ports:
//   rem, quo, divisor    current partial remainder, quotient/dividend shift reg, divisor
//   rem_next, quo_next   values after shifting {rem,quo} left and trial-subtracting divisor
module div_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rem,
  input  logic [DATA_WIDTH-1:0] quo,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] rem_next,
  output logic [DATA_WIDTH-1:0] quo_next
);
  // One extra bit: the shifted remainder can reach 2*divisor-1.
  logic [DATA_WIDTH:0] rem_sh;
  logic [DATA_WIDTH:0] diff;

  always_comb begin
    rem_sh = {rem, quo[DATA_WIDTH-1]};
    diff   = rem_sh - {1'b0, divisor};
    if (!diff[DATA_WIDTH]) begin
      rem_next = diff[DATA_WIDTH-1:0];
      quo_next = {quo[DATA_WIDTH-2:0], 1'b1};
    end else begin
      rem_next = rem_sh[DATA_WIDTH-1:0];
      quo_next = {quo[DATA_WIDTH-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit for the EX stage.
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-high reset
//   bus   div_ctrl_if.slave: request/op/operands/flush in; busy/stall/valid/result out
// Runs 32 restoring steps on magnitudes, then sign-corrects. Divide-by-zero and
// signed overflow skip iteration and produce their result one cycle after acceptance.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DIV_DATA_WIDTH,
  parameter int CNT_WIDTH  = DIV_CNT_WIDTH
) (
  input logic clk,
  input logic rst,
  div_ctrl_if.slave bus
);

  div_state_e            state;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  rem_sel_q;
  logic                  q_neg_q;
  logic                  r_neg_q;
  logic [DATA_WIDTH-1:0] div_q;
  logic [DATA_WIDTH-1:0] rem_q;
  logic [DATA_WIDTH-1:0] quo_q;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] result_q;

  div_op_e               op_in;
  logic                  sgn_in;
  logic                  a_neg;
  logic                  b_neg;
  logic [DATA_WIDTH-1:0] a_abs;
  logic [DATA_WIDTH-1:0] b_abs;
  logic                  div_zero;
  logic                  overflow;
  logic [DATA_WIDTH-1:0] rem_next;
  logic [DATA_WIDTH-1:0] quo_next;
  logic [DATA_WIDTH-1:0] final_res;

  always_comb begin
    op_in    = div_op_e'(bus.div_op_i);
    sgn_in   = is_signed_op(op_in);
    a_neg    = sgn_in & bus.dividend_i[DATA_WIDTH-1];
    b_neg    = sgn_in & bus.divisor_i[DATA_WIDTH-1];
    a_abs    = a_neg ? ('0 - bus.dividend_i) : bus.dividend_i;
    b_abs    = b_neg ? ('0 - bus.divisor_i) : bus.divisor_i;
    div_zero = (bus.divisor_i == '0);
    overflow = sgn_in && (bus.dividend_i == {1'b1, {(DATA_WIDTH-1){1'b0}}})
                      && (bus.divisor_i == '1);
  end

  div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (div_q),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // Sign fix-up applied to the outcome of the final step so the result is
  // registered on the same edge that enters DONE.
  always_comb begin
    if (rem_sel_q) final_res = r_neg_q ? ('0 - rem_next) : rem_next;
    else           final_res = q_neg_q ? ('0 - quo_next) : quo_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= DIV_STATE_IDLE;
      cnt       <= '0;
      rem_sel_q <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      div_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      valid_q   <= 1'b0;
      result_q  <= '0;
    end else if (bus.flush_i) begin
      state    <= DIV_STATE_IDLE;
      cnt      <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      case (state)
        DIV_STATE_IDLE: begin
          valid_q  <= 1'b0;
          result_q <= '0;
          if (bus.div_req_i) begin
            rem_sel_q <= is_rem_op(op_in);
            cnt       <= '0;
            if (div_zero) begin
              result_q <= is_rem_op(op_in) ? bus.dividend_i : '1;
              valid_q  <= 1'b1;
              state    <= DIV_STATE_DONE;
            end else if (overflow) begin
              result_q <= is_rem_op(op_in) ? '0 : {1'b1, {(DATA_WIDTH-1){1'b0}}};
              valid_q  <= 1'b1;
              state    <= DIV_STATE_DONE;
            end else begin
              rem_q   <= '0;
              quo_q   <= a_abs;
              div_q   <= b_abs;
              q_neg_q <= a_neg ^ b_neg;
              r_neg_q <= a_neg;
              state   <= DIV_STATE_CALC;
            end
          end
        end
        DIV_STATE_CALC: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          cnt   <= cnt + CNT_WIDTH'(1);
          if (cnt == CNT_WIDTH'(DATA_WIDTH-1)) begin
            valid_q  <= 1'b1;
            result_q <= final_res;
            state    <= DIV_STATE_DONE;
          end
        end
        DIV_STATE_DONE: begin
          valid_q  <= 1'b0;
          result_q <= '0;
          state    <= DIV_STATE_IDLE;
        end
        default: begin
          valid_q  <= 1'b0;
          result_q <= '0;
          state    <= DIV_STATE_IDLE;
        end
      endcase
    end
  end

  assign bus.div_busy_o   = (state != DIV_STATE_IDLE);
  assign bus.div_stall_o  = ~bus.flush_i &
                            (((state == DIV_STATE_IDLE) & bus.div_req_i) |
                             (state == DIV_STATE_CALC));
  assign bus.div_valid_o  = valid_q & ~bus.flush_i;
  assign bus.div_result_o = result_q;

endmodule

// File: tb/tb_div_ctrl.sv
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  div_ctrl_if #(.DATA_WIDTH(32)) bus ();

  div_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
    end
  endtask

  // Reference result from the RV32M rules using plain language arithmetic.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa;
    int sb;
    logic is_rem;
    is_rem = op[1];
    if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
        return is_rem ? 32'd0 : 32'h8000_0000;
      sa = a;
      sb = b;
      return is_rem ? 32'(sa % sb) : 32'(sa / sb);
    end
    return is_rem ? (a % b) : (a / b);
  endfunction

  // Called at a negedge with the divider idle. Drives a request, counts cycles
  // to the valid strobe and checks latency, stall, busy and result. With keep
  // set, req stays high through DONE so the next call is a back-to-back accept.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit keep);
    int  lat;
    int  exp_lat;
    bit  got;
    bit  fast;
    fast    = (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    exp_lat = fast ? 1 : 33;
    bus.div_req_i  = 1'b1;
    bus.div_op_i   = op;
    bus.dividend_i = a;
    bus.divisor_i  = b;
    #1;
    check({name, "_stall_T"}, {31'd0, bus.div_stall_o}, 32'd1);
    check({name, "_busy_T"}, {31'd0, bus.div_busy_o}, 32'd0);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (bus.div_valid_o) got = 1'b1;
      else check({name, "_stall_calc"}, {31'd0, bus.div_stall_o}, 32'd1);
      // Operands are only sampled at acceptance.
      if (lat == 1) begin
        bus.dividend_i = $urandom;
        bus.divisor_i  = $urandom;
      end
    end
    check({name, "_valid_seen"}, {31'd0, got}, 32'd1);
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_result"}, bus.div_result_o, exp);
    check({name, "_stall_done"}, {31'd0, bus.div_stall_o}, 32'd0);
    check({name, "_busy_done"}, {31'd0, bus.div_busy_o}, 32'd1);
    if (!keep) bus.div_req_i = 1'b0;
    @(negedge clk);
    check({name, "_busy_after"}, {31'd0, bus.div_busy_o}, 32'd0);
    check({name, "_valid_after"}, {31'd0, bus.div_valid_o}, 32'd0);
    check({name, "_result_after"}, bus.div_result_o, 32'd0);
    check({name, "_stall_after"}, {31'd0, bus.div_stall_o}, {31'd0, keep});
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          sel;
    int          vcount;
    checks   = 0;
    failures = 0;
    rst            = 1'b1;
    bus.div_req_i  = 1'b0;
    bus.div_op_i   = 2'b00;
    bus.dividend_i = '0;
    bus.divisor_i  = '0;
    bus.flush_i    = 1'b0;
    #1;
    check("reset_busy", {31'd0, bus.div_busy_o}, 32'd0);
    check("reset_stall", {31'd0, bus.div_stall_o}, 32'd0);
    check("reset_valid", {31'd0, bus.div_valid_o}, 32'd0);
    check("reset_result", bus.div_result_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op("divu_100_7", DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0);
    run_op("remu_100_7", DIV_OP_REMU, 32'd100, 32'd7, 32'd2, 1'b0);
    run_op("div_m7_2", DIV_OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
    run_op("rem_m7_2", DIV_OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
    run_op("div_7_m2", DIV_OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
    run_op("rem_7_m2", DIV_OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0);
    run_op("divu_5_0", DIV_OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0);
    run_op("rem_5_0", DIV_OP_REM, 32'd5, 32'd0, 32'd5, 1'b0);
    run_op("div_ovf", DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run_op("rem_ovf", DIV_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);

    // Flush during the 10th CALC cycle.
    bus.div_req_i  = 1'b1;
    bus.div_op_i   = DIV_OP_DIVU;
    bus.dividend_i = 32'd1000;
    bus.divisor_i  = 32'd3;
    repeat (10) @(negedge clk);
    check("flush_pre_busy", {31'd0, bus.div_busy_o}, 32'd1);
    bus.flush_i   = 1'b1;
    bus.div_req_i = 1'b0;
    #1;
    check("flush_stall_forced", {31'd0, bus.div_stall_o}, 32'd0);
    @(negedge clk);
    check("flush_busy", {31'd0, bus.div_busy_o}, 32'd0);
    check("flush_stall", {31'd0, bus.div_stall_o}, 32'd0);
    bus.flush_i = 1'b0;
    vcount = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.div_valid_o) vcount++;
    end
    check("flush_no_valid", vcount, 0);
    run_op("divu_9_3", DIV_OP_DIVU, 32'd9, 32'd3, 32'd3, 1'b0);

    // Flush and request together in IDLE: nothing accepted.
    bus.div_req_i  = 1'b1;
    bus.flush_i    = 1'b1;
    bus.div_op_i   = DIV_OP_DIVU;
    bus.dividend_i = 32'd8;
    bus.divisor_i  = 32'd0;
    #1;
    check("flushreq_stall", {31'd0, bus.div_stall_o}, 32'd0);
    @(negedge clk);
    check("flushreq_busy", {31'd0, bus.div_busy_o}, 32'd0);
    check("flushreq_valid", {31'd0, bus.div_valid_o}, 32'd0);
    bus.div_req_i = 1'b0;
    bus.flush_i   = 1'b0;
    @(negedge clk);

    // Reset in the middle of CALC.
    bus.div_req_i  = 1'b1;
    bus.div_op_i   = DIV_OP_DIV;
    bus.dividend_i = 32'h1234_5678;
    bus.divisor_i  = 32'd77;
    repeat (6) @(negedge clk);
    rst           = 1'b1;
    bus.div_req_i = 1'b0;
    #1;
    check("rst_mid_busy", {31'd0, bus.div_busy_o}, 32'd0);
    check("rst_mid_stall", {31'd0, bus.div_stall_o}, 32'd0);
    check("rst_mid_valid", {31'd0, bus.div_valid_o}, 32'd0);
    check("rst_mid_result", bus.div_result_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_after_valid", {31'd0, bus.div_valid_o}, 32'd0);

    // Back-to-back: second request held through DONE, accepted in the next IDLE.
    run_op("b2b_divu_6_3", DIV_OP_DIVU, 32'd6, 32'd3, 32'd2, 1'b1);
    run_op("b2b_remu_7_4", DIV_OP_REMU, 32'd7, 32'd4, 32'd3, 1'b0);

    // Randomized operations against the reference model.
    for (int n = 0; n < 24; n++) begin
      op  = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 7);
      a   = $urandom;
      b   = $urandom;
      case (sel)
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 200)); b = 32'($urandom_range(1, 20)); end
        3: b = 32'($urandom_range(1, 1000)) | {32{$urandom_range(0, 1) == 1}} << 16;
        default: ;
      endcase
      run_op("rand", op, a, b, ref_div(op, a, b), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
